multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the RV32I-subset processor datapath through fetch, decode, execute, memory and writeback over a single shared memory port. It generates ALU select and alu_control, PC, instruction-register and register-file write enables, and memory requests with a req/ready handshake. It also keeps a retired-instruction counter and a memory-timeout watchdog. It sits between the instruction register and the datapath muxes, replacing single-cycle control decode.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)
TIMEOUT, 255, max cycles mem_req may wait for mem_ready before TRAP; 0 disables watchdog

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct7_5  input  1  instr[30]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes access this cycle
mem_req  output  1  memory access request
mem_we  output  1  write strobe (valid with mem_req)
ir_write  output  1  load instruction register
pc_write  output  1  load PC from result mux
reg_write  output  1  register-file write enable
alu_src_a  output  2  00 PC, 01 rs1, 10 old PC
alu_src_b  output  2  00 rs2, 01 imm, 10 const 4
alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
result_src  output  2  00 ALU result, 01 ALUOut reg, 10 mem data
state_out  output  4  current state encoding
instr_retired  output  1  one-cycle pulse per completed instruction
retired_count  output  CNT_W  retired-instruction counter
trap  output  1  high while in TRAP

Behaviour:
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JAL=10, TRAP=11.
- Outputs are Moore functions of state, except where gated by mem_ready, zero or funct3 as stated below. All unlisted outputs are 0.
- Reset: async entry to FETCH. While reset is high, all outputs are 0, including mem_req. retired_count=0 and the watchdog counter is 0.
- Reset mid-operation abandons any pending memory access. There is no writeback and no retire.
- FETCH: mem_req=1, alu_src_a=00, alu_src_b=10, add, result_src=00. ir_write and pc_write are asserted only in the cycle mem_ready=1, which also transitions to DECODE. Otherwise the FSM stays in FETCH.
- DECODE: alu_src_a=10, alu_src_b=01, add (branch target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> TRAP
- funct3 decode for EXEC_R and EXEC_I: 000 add (sub if EXEC_R and funct7_5=1), 111 and, 110 or, 100 xor, 010 slt, 001 sll, 101 srl (sra unsupported; funct7_5 ignored for 101). funct3=011 is detected in DECODE and goes to TRAP.
- EXEC_R: a=01, b=00, decoded op, then WB_ALU. EXEC_I: a=01, b=01, decoded op, then WB_ALU.
- WB_ALU: result_src=01, reg_write=1, instr_retired=1, then FETCH.
- MEM_ADDR: a=01, b=01, add. Goes to MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_req=1, result_src=01 (address). On mem_ready go to WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, result_src=01 (address). On mem_ready: instr_retired=1, then FETCH.
- WB_MEM: result_src=10, reg_write=1, instr_retired=1, then FETCH.
- BRANCH: a=01, b=00, sub, result_src=01. pc_write=(funct3=000 & zero) | (funct3=001 & ~zero); other funct3 values never take the branch. instr_retired=1, then FETCH.
- JAL: a=10, b=10, add, result_src=00, reg_write=1 (rd=old PC+4). Then one cycle pc_write with result_src=01; this is a second JAL cycle tracked by an internal flag. instr_retired=1 on the second cycle, then FETCH.
- Watchdog: a counter increments each cycle that mem_req=1 and mem_ready=0, and clears on any cycle mem_req=0 or mem_ready=1. If TIMEOUT!=0 and the counter reaches TIMEOUT, the next state is TRAP. mem_ready arriving in the same cycle as the limit takes priority, so the access completes.
- TRAP: trap=1, all other outputs 0. It is absorbing; only reset exits.
- mem_ready is ignored in states with mem_req=0.
- retired_count increments on each instr_retired, wraps at 2^CNT_W-1 -> 0, and holds in TRAP.

Test Plan:
- Reset released, mem_ready=1 constantly, R-type add (opcode 0110011, funct3 000, funct7_5 0) -> states 0,1,2,7,0; reg_write=1 only in cycle 4; instr_retired pulse; retired_count=1.
- Load with mem_ready delayed 3 cycles in FETCH and 2 in MEM_RD -> mem_req held high throughout; ir_write one cycle; sequence 0,0,0,0,1,4,5,5,5,8; retired_count=1.
- beq with zero=1 then zero=0 -> pc_write=1 in BRANCH only for the first; both retire; alu_control=001.
- Store then sub (funct7_5=1) -> mem_we=1 only in MEM_WR; EXEC_R alu_control=001.
- Opcode 1111111 -> TRAP from DECODE, trap=1, outputs 0 for 10 cycles; assert reset -> state_out=0, trap=0.
- TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 waiting cycles. Rerun with mem_ready=1 on the 4th cycle -> DECODE. CNT_W=2, 5 instructions -> retired_count=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset datapath.
// Sequences fetch/decode/execute/memory/writeback over one shared memory
// port, drives the datapath mux selects and write enables, counts retired
// instructions and traps on a stalled memory access.
module multicycle_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       result_src,
    output logic [3:0]       state_out,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retired_count,
    output logic             trap
);

    // Watchdog counter only has to reach TIMEOUT-1 before the trap fires.
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t           state_q, state_d;
    logic             jal2_q, jal2_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       alu_op;
    logic             br_taken;
    logic             wd_trip;

    // ALU operation for R/I execute; funct3=011 never reaches execute.
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (state_q == S_EXEC_R && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b100:  alu_op = ALU_XOR;
            3'b010:  alu_op = ALU_SLT;
            3'b001:  alu_op = ALU_SLL;
            3'b101:  alu_op = ALU_SRL;
            default: alu_op = ALU_ADD;
        endcase
    end

    assign br_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

    // Control outputs: Moore decode of the state, gated by mem_ready/zero where
    // the same-cycle handshake requires it, and forced low while in reset.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_control   = ALU_ADD;
        result_src    = 2'b00;
        instr_retired = 1'b0;
        trap          = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b10;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_EXEC_R: begin
                    alu_src_a   = 2'b01;
                    alu_control = alu_op;
                end
                S_EXEC_I: begin
                    alu_src_a   = 2'b01;
                    alu_src_b   = 2'b01;
                    alu_control = alu_op;
                end
                S_WB_ALU: begin
                    result_src    = 2'b01;
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEM_RD: begin
                    mem_req    = 1'b1;
                    result_src = 2'b01;
                end
                S_MEM_WR: begin
                    mem_req       = 1'b1;
                    mem_we        = 1'b1;
                    result_src    = 2'b01;
                    instr_retired = mem_ready;
                end
                S_WB_MEM: begin
                    result_src    = 2'b10;
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 2'b01;
                    alu_control   = ALU_SUB;
                    result_src    = 2'b01;
                    pc_write      = br_taken;
                    instr_retired = 1'b1;
                end
                S_JAL: begin
                    if (!jal2_q) begin
                        // Link: rd <= old PC + 4
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b10;
                        reg_write = 1'b1;
                    end else begin
                        // Jump: PC <= target held in ALUOut
                        result_src    = 2'b01;
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                    end
                end
                S_TRAP:  trap = 1'b1;
                default: trap = 1'b0;
            endcase
        end
    end

    // A stalled access that has waited TIMEOUT cycles traps, unless the
    // memory answers in that very cycle.
    assign wd_trip = (TIMEOUT > 0) && mem_req && !mem_ready && (wd_q == WD_LIMIT);

    // Next-state, JAL phase flag, watchdog and retire-counter updates.
    always_comb begin
        state_d = state_q;
        jal2_d  = 1'b0;
        wd_d    = (mem_req && !mem_ready) ? wd_q + WD_W'(1) : '0;
        cnt_d   = cnt_q + CNT_W'(instr_retired);
        case (state_q)
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (wd_trip) state_d = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:         state_d = (funct3 == 3'b011) ? S_TRAP : S_EXEC_R;
                    OP_I:         state_d = (funct3 == 3'b011) ? S_TRAP : S_EXEC_I;
                    OP_LD, OP_ST: state_d = S_MEM_ADDR;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR:         state_d = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)    state_d = S_WB_MEM;
                else if (wd_trip) state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem_ready)    state_d = S_FETCH;
                else if (wd_trip) state_d = S_TRAP;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH: state_d = S_FETCH;
            S_JAL: begin
                if (!jal2_q) jal2_d  = 1'b1;
                else         state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // State and counters; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            jal2_q  <= 1'b0;
            wd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            jal2_q  <= jal2_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_out     = state_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a transaction-level model predicts,
// per instruction, the cycle-by-cycle trace of states, selects and strobes;
// a monitor collects the DUT trace and compares it when the instruction
// retires or traps.
module tb_multicycle_ctrl;

    localparam int TB_CNT_W = 2;
    localparam int TB_TO    = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5;
    localparam int K_ILL = 6, K_WDF = 7, K_WDM = 8;

    // strobe flags {mem_req, mem_we, ir_write, pc_write, reg_write, retired, trap}
    localparam logic [6:0] F_MR = 7'b1000000, F_MW = 7'b0100000, F_IW = 7'b0010000;
    localparam logic [6:0] F_PW = 7'b0001000, F_RW = 7'b0000100, F_RET = 7'b0000010;
    localparam logic [6:0] F_TR = 7'b0000001;

    localparam logic [19:0] TRAP_VEC = {5'b0, 2'b0, 2'b0, 3'b0, 2'b0, 4'd11, 1'b0, 1'b1};

    typedef struct packed {
        logic [4:0]          n;
        logic [63:0]         st;
        logic [95:0]         sel;
        logic [47:0]         alu;
        logic [111:0]        fl;
        logic [TB_CNT_W-1:0] cnt;
    } rec_t;

    bit clk;
    logic reset, funct7_5, zero, mem_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic mem_req, mem_we, ir_write, pc_write, reg_write, instr_retired, trap;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control;
    logic [3:0] state_out;
    logic [TB_CNT_W-1:0] retired_count;

    multicycle_ctrl #(.CNT_W(TB_CNT_W), .TIMEOUT(TB_TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .result_src(result_src),
        .state_out(state_out), .instr_retired(instr_retired),
        .retired_count(retired_count), .trap(trap)
    );

    initial forever #5 clk = ~clk;

    wire [19:0] ctl_vec = {mem_req, mem_we, ir_write, pc_write, reg_write, alu_src_a,
                           alu_src_b, alu_control, result_src, state_out, instr_retired, trap};

    rec_t sb[$];
    rec_t exp_r;
    logic [15:0] plan_rdy;
    logic [TB_CNT_W-1:0] model_cnt;
    int vectors = 0;
    int fails = 0;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] want);
        vectors++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input bit is_r, input logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b100:  return 3'b100;
            3'b010:  return 3'b101;
            3'b001:  return 3'b110;
            3'b101:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op == OP_R || op == OP_I || op == OP_LD || op == OP_ST || op == OP_BR || op == OP_JAL;
    endfunction

    // Append one predicted cycle: state, {a,b,result_src}, alu op, strobes, planned mem_ready.
    task automatic emit(input logic [3:0] s, input logic [5:0] sl, input logic [2:0] op,
                        input logic [6:0] f, input logic rdy);
        int p;
        p = int'(exp_r.n);
        exp_r.st[p*4 +: 4]  = s;
        exp_r.sel[p*6 +: 6] = sl;
        exp_r.alu[p*3 +: 3] = op;
        exp_r.fl[p*7 +: 7]  = f;
        plan_rdy[p]         = rdy;
        exp_r.n             = exp_r.n + 5'd1;
    endtask

    // Predict an instruction's trace from the ISA-level rules.
    task automatic build(input int kind, input logic [6:0] opc, input logic [2:0] f3,
                         input logic f7, input logic zf, input int fd, input int md);
        exp_r    = '0;
        plan_rdy = '0;
        exp_r.cnt = model_cnt;
        if (kind == K_WDF) begin
            for (int i = 0; i < TB_TO; i++) emit(4'd0, 6'b001000, 3'b000, F_MR, 1'b0);
            emit(4'd11, 6'b0, 3'b000, F_TR, rbit());
            return;
        end
        for (int i = 0; i < fd; i++) emit(4'd0, 6'b001000, 3'b000, F_MR, 1'b0);
        emit(4'd0, 6'b001000, 3'b000, F_MR | F_IW | F_PW, 1'b1);
        emit(4'd1, 6'b100100, 3'b000, 7'b0, rbit());
        case (kind)
            K_R: begin
                emit(4'd2, 6'b010000, alu_of(f3, 1'b1, f7), 7'b0, rbit());
                emit(4'd7, 6'b000001, 3'b000, F_RW | F_RET, rbit());
            end
            K_I: begin
                emit(4'd3, 6'b010100, alu_of(f3, 1'b0, f7), 7'b0, rbit());
                emit(4'd7, 6'b000001, 3'b000, F_RW | F_RET, rbit());
            end
            K_LD: begin
                emit(4'd4, 6'b010100, 3'b000, 7'b0, rbit());
                for (int i = 0; i < md; i++) emit(4'd5, 6'b000001, 3'b000, F_MR, 1'b0);
                emit(4'd5, 6'b000001, 3'b000, F_MR, 1'b1);
                emit(4'd8, 6'b000010, 3'b000, F_RW | F_RET, rbit());
            end
            K_WDM: begin
                emit(4'd4, 6'b010100, 3'b000, 7'b0, rbit());
                for (int i = 0; i < TB_TO; i++) emit(4'd5, 6'b000001, 3'b000, F_MR, 1'b0);
                emit(4'd11, 6'b0, 3'b000, F_TR, rbit());
            end
            K_ST: begin
                emit(4'd4, 6'b010100, 3'b000, 7'b0, rbit());
                for (int i = 0; i < md; i++) emit(4'd6, 6'b000001, 3'b000, F_MR | F_MW, 1'b0);
                emit(4'd6, 6'b000001, 3'b000, F_MR | F_MW | F_RET, 1'b1);
            end
            K_BR: begin
                if ((f3 == 3'b000 && zf) || (f3 == 3'b001 && !zf))
                    emit(4'd9, 6'b010001, 3'b001, F_PW | F_RET, rbit());
                else
                    emit(4'd9, 6'b010001, 3'b001, F_RET, rbit());
            end
            K_JAL: begin
                emit(4'd10, 6'b101000, 3'b000, F_RW, rbit());
                emit(4'd10, 6'b000001, 3'b000, F_PW | F_RET, rbit());
            end
            default: emit(4'd11, 6'b0, 3'b000, F_TR, rbit());
        endcase
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = rbit();
        repeat (2) @(posedge clk);
        #1 reset  = 1'b0;
        model_cnt = '0;
    endtask

    // Issue one instruction; optionally abandon it with a reset part-way through.
    task automatic run_instr(input int kind, input logic [6:0] opc, input logic [2:0] f3,
                             input logic f7, input logic zf, input int fd, input int md,
                             input bit abort);
        int  ncyc;
        bit  is_trap;
        build(kind, opc, f3, f7, zf, fd, md);
        is_trap = (kind >= K_ILL);
        ncyc    = int'(exp_r.n);
        if (abort) begin
            ncyc = int'($urandom_range(1, ncyc - 1));
        end else begin
            sb.push_back(exp_r);
            if (!is_trap) model_cnt = model_cnt + 1'b1;
        end
        for (int c = 0; c < ncyc; c++) begin
            opcode = opc; funct3 = f3; funct7_5 = f7; zero = zf;
            mem_ready = plan_rdy[c];
            @(posedge clk); #1;
        end
        if (is_trap) begin
            for (int c = 0; c < 10; c++) begin
                opcode = 7'($urandom); mem_ready = rbit(); zero = rbit();
                @(posedge clk); #1;
            end
        end
        if (is_trap || abort) do_reset();
    endtask

    // Monitor: collect the DUT trace and close it on retire or trap.
    rec_t obs = '0;
    rec_t e;
    bit in_trap = 1'b0;
    logic [TB_CNT_W-1:0] trap_cnt;
    int p;
    always @(negedge clk) begin
        if (reset) begin
            cmp("reset_outputs", 128'({ctl_vec, retired_count}), 128'd0);
            obs     = '0;
            in_trap = 1'b0;
        end else if (in_trap) begin
            cmp("trap_hold", 128'({ctl_vec, retired_count}), 128'({TRAP_VEC, trap_cnt}));
        end else begin
            if (obs.n == 5'd16) begin
                cmp("trace_overflow", 128'(obs.n), 128'd0);
                obs = '0;
            end
            p = int'(obs.n);
            obs.st[p*4 +: 4]  = state_out;
            obs.sel[p*6 +: 6] = {alu_src_a, alu_src_b, result_src};
            obs.alu[p*3 +: 3] = alu_control;
            obs.fl[p*7 +: 7]  = {mem_req, mem_we, ir_write, pc_write, reg_write, instr_retired, trap};
            obs.n             = obs.n + 5'd1;
            if (instr_retired === 1'b1 || trap === 1'b1) begin
                obs.cnt = retired_count;
                if (sb.size() == 0) begin
                    cmp("unexpected_completion", 128'(obs.st), 128'd0);
                end else begin
                    e = sb.pop_front();
                    cmp("length", 128'(obs.n), 128'(e.n));
                    cmp("states", 128'(obs.st), 128'(e.st));
                    cmp("selects", 128'(obs.sel), 128'(e.sel));
                    cmp("alu_control", 128'(obs.alu), 128'(e.alu));
                    cmp("strobes", 128'(obs.fl), 128'(e.fl));
                    cmp("retired_count", 128'(obs.cnt), 128'(e.cnt));
                end
                if (trap === 1'b1) begin
                    in_trap  = 1'b1;
                    trap_cnt = retired_count;
                end
                obs = '0;
            end
        end
    end

    // Stimulus: directed scenarios, then randomized instruction mix.
    initial begin
        int sel, kind, fd, md;
        logic [6:0] opc;
        logic [2:0] f3;
        bit abort;
        reset = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        model_cnt = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run_instr(K_R,   OP_R,   3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(K_LD,  OP_LD,  3'b010, 1'b0, 1'b0, 3, 2, 1'b0);
        run_instr(K_BR,  OP_BR,  3'b000, 1'b0, 1'b1, 0, 0, 1'b0);
        run_instr(K_BR,  OP_BR,  3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(K_ST,  OP_ST,  3'b010, 1'b0, 1'b0, 1, 1, 1'b0);
        run_instr(K_R,   OP_R,   3'b000, 1'b1, 1'b0, 0, 0, 1'b0);
        run_instr(K_I,   OP_I,   3'b000, 1'b1, 1'b0, 3, 0, 1'b0);
        run_instr(K_JAL, OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(K_ILL, 7'h7F,  3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(K_WDF, OP_R,   3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(K_WDM, OP_LD,  3'b010, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(K_ILL, OP_I,   3'b011, 1'b0, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < 160; i++) begin
            sel   = int'($urandom_range(0, 99));
            fd    = int'($urandom_range(0, 3));
            md    = int'($urandom_range(0, 3));
            f3    = 3'($urandom);
            abort = 1'b0;
            if (sel < 14)      begin kind = K_R;   opc = OP_R;   end
            else if (sel < 28) begin kind = K_I;   opc = OP_I;   end
            else if (sel < 44) begin kind = K_LD;  opc = OP_LD;  end
            else if (sel < 58) begin kind = K_ST;  opc = OP_ST;  end
            else if (sel < 74) begin kind = K_BR;  opc = OP_BR;  end
            else if (sel < 88) begin kind = K_JAL; opc = OP_JAL; end
            else if (sel < 94) begin
                kind = K_ILL;
                opc  = 7'($urandom);
                while (is_legal(opc)) opc = 7'($urandom);
            end else begin
                kind = K_ILL;
                opc  = rbit() ? OP_R : OP_I;
                f3   = 3'b011;
            end
            if ((kind == K_R || kind == K_I) && f3 == 3'b011) f3 = 3'b000;
            if (kind < K_ILL && $urandom_range(0, 19) == 0) abort = 1'b1;
            run_instr(kind, opc, f3, rbit(), rbit(), fd, md, abort);
        end

        cmp("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
